serializer: RTL and testbench

Parallel-to-serial transmitter for the XOR cipher datapath. It accepts a DATA_SIZE-bit word on a start strobe and shifts it out one bit per enable strobe, MSB first. Alongside the data it drives a loading frame that the matching receive-side deserializer consumes directly: its iEn, iData_in and iLoading inputs connect to this block's shared iEn, oData_out and oLoading. It sits on the output side of the cipher core and feeds ciphertext to the pin interface or to a loopback receiver.

---
 rtl/serializer.sv | 145 ++++++++++++++
 tb/tb_serializer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer.sv
// -----------------------------------------------------------------------------
// serializer
//
// Parallel-to-serial transmitter for the XOR cipher datapath. A DATA_SIZE-bit
// word is captured on an accepted start strobe and shifted out one bit per
// iEn strobe. The serial data is framed by oLoading, which the matching
// deserializer consumes directly.
//
// Configuration macro:
//   SERIALIZER_LSB_FIRST_EN  defined   -> LSB first, shift register moves right
//                            undefined -> MSB first (default), moves left
//
// Parameters:
//   DATA_SIZE     word width in bits (>= 2)
//
// Ports:
//   iClk          clock, rising edge
//   iRst          asynchronous reset, active-low
//   iEn           bit-rate enable shared with the receiver
//   iStart        load request, honoured only in IDLE
//   iData         word to transmit, captured on the accepting edge
//   oData_out     registered serial bit, 0 outside SHIFT
//   oLoading      registered frame valid, high only in SHIFT
//   oBusy         high in SHIFT and DONE
//   oDone         one-cycle pulse marking the end of a frame
//   oBit_counter  number of bits the receiver has already consumed
// -----------------------------------------------------------------------------
module serializer #(
    parameter int DATA_SIZE = 32
) (
    input  logic                         iClk,
    input  logic                         iRst,
    input  logic                         iEn,
    input  logic                         iStart,
    input  logic [DATA_SIZE-1:0]         iData,
    output logic                         oData_out,
    output logic                         oLoading,
    output logic                         oBusy,
    output logic                         oDone,
    output logic [$clog2(DATA_SIZE):0]   oBit_counter
);

    // One extra bit so that DATA_SIZE itself fits without wrapping.
    localparam int CW = $clog2(DATA_SIZE) + 1;

    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_SIZE - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DATA_SIZE);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]           state;
    logic [DATA_SIZE-1:0] shift_reg;
    logic [CW-1:0]        counter;

    // Bit-order helpers: the first bit driven on acceptance, the bit that
    // follows the current one, and the register after one shift.
`ifdef SERIALIZER_LSB_FIRST_EN
    function automatic logic firstBit(input logic [DATA_SIZE-1:0] word);
        return word[0];
    endfunction

    function automatic logic nextBit(input logic [DATA_SIZE-1:0] word);
        return word[1];
    endfunction

    function automatic logic [DATA_SIZE-1:0] shiftOnce(input logic [DATA_SIZE-1:0] word);
        return {1'b0, word[DATA_SIZE-1:1]};
    endfunction
`else
    function automatic logic firstBit(input logic [DATA_SIZE-1:0] word);
        return word[DATA_SIZE-1];
    endfunction

    function automatic logic nextBit(input logic [DATA_SIZE-1:0] word);
        return word[DATA_SIZE-2];
    endfunction

    function automatic logic [DATA_SIZE-1:0] shiftOnce(input logic [DATA_SIZE-1:0] word);
        return {word[DATA_SIZE-2:0], 1'b0};
    endfunction
`endif

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state        <= IDLE;
            shift_reg    <= '0;
            counter      <= '0;
            oData_out    <= 1'b0;
            oLoading     <= 1'b0;
            oBusy        <= 1'b0;
            oDone        <= 1'b0;
            oBit_counter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // iEn is deliberately not looked at here: the accepting
                    // edge only presents the first bit, it never consumes one.
                    if (iStart) begin
                        shift_reg    <= iData;
                        counter      <= '0;
                        oBit_counter <= '0;
                        oData_out    <= firstBit(iData);
                        oLoading     <= 1'b1;
                        oBusy        <= 1'b1;
                        state        <= SHIFT;
                    end
                end

                SHIFT: begin
                    // Each iEn edge is the receiver's sample point for the
                    // bit currently on oData_out.
                    if (iEn) begin
                        if (counter == LAST_IDX) begin
                            oBit_counter <= FULL_CNT;
                            oLoading     <= 1'b0;
                            oData_out    <= 1'b0;
                            oDone        <= 1'b1;
                            state        <= DONE;
                        end else begin
                            shift_reg    <= shiftOnce(shift_reg);
                            oData_out    <= nextBit(shift_reg);
                            counter      <= counter + CW'(1);
                            oBit_counter <= oBit_counter + CW'(1);
                        end
                    end
                end

                DONE: begin
                    // Start requests here are dropped; the earliest new word
                    // is accepted one cycle after DONE.
                    oDone <= 1'b0;
                    oBusy <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serializer.sv
// -----------------------------------------------------------------------------
// tb_serializer
//
// Directed bench for serializer with DATA_SIZE = 8. Inputs change and outputs
// are sampled on the falling clock edge. Expected bit order follows the
// SERIALIZER_LSB_FIRST_EN macro so the same bench covers both builds.
// -----------------------------------------------------------------------------
module tb_serializer;

    localparam int DW = 8;

    logic          iClk = 1'b0;
    logic          iRst;
    logic          iEn;
    logic          iStart;
    logic [DW-1:0] iData;
    logic          oData_out;
    logic          oLoading;
    logic          oBusy;
    logic          oDone;
    logic [3:0]    oBit_counter;

    // {oLoading, oBusy, oDone, oData_out, oBit_counter}
    logic [7:0]    obs;
    logic [7:0]    exp;
    logic [7:0]    rx;

    int ntests = 0;
    int nfail  = 0;

    serializer #(.DATA_SIZE(DW)) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iEn          (iEn),
        .iStart       (iStart),
        .iData        (iData),
        .oData_out    (oData_out),
        .oLoading     (oLoading),
        .oBusy        (oBusy),
        .oDone        (oDone),
        .oBit_counter (oBit_counter)
    );

    always #5 iClk = ~iClk;

    assign obs = {oLoading, oBusy, oDone, oData_out, oBit_counter};

    // Bit expected on the wire at frame position i.
    function automatic logic expBit(input logic [7:0] w, input int i);
`ifdef SERIALIZER_LSB_FIRST_EN
        return w[i];
`else
        return w[7-i];
`endif
    endfunction

    // Receiver-side assembly of one sampled bit.
    function automatic logic [7:0] rxShift(input logic [7:0] acc, input logic b);
`ifdef SERIALIZER_LSB_FIRST_EN
        return {b, acc[7:1]};
`else
        return {acc[6:0], b};
`endif
    endfunction

    task automatic test_reset();
        iRst = 1'b0; iEn = 1'b0; iStart = 1'b0; iData = '0;
        #2;
        exp = 8'h00;
        ntests++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL reset: got %b expected %b", obs, exp);
        end
        @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        ntests++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL idle_after_reset: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_basic(input logic [7:0] w);
        iData = w; iStart = 1'b1; iEn = 1'b1;
        @(negedge iClk);
        iStart = 1'b0; iData = 8'h00;
        for (int i = 0; i < 8; i++) begin
            exp = {1'b1, 1'b1, 1'b0, expBit(w, i), 4'(i)};
            ntests++;
            if (obs !== exp) begin
                nfail++;
                $display("FAIL basic_%h_bit%0d: got %b expected %b", w, i, obs, exp);
            end
            @(negedge iClk);
        end
        exp = {1'b0, 1'b1, 1'b1, 1'b0, 4'd8};
        ntests++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL basic_%h_done: got %b expected %b", w, obs, exp);
        end
        @(negedge iClk);
        @(negedge iClk);
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 4'd8};
        ntests++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL basic_%h_idle: got %b expected %b", w, obs, exp);
        end
    endtask

    task automatic test_en_gaps();
        rx = 8'h00;
        iData = 8'hA5; iStart = 1'b1; iEn = 1'b0;
        @(negedge iClk);
        iStart = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 3; k++) begin
                exp = {1'b1, 1'b1, 1'b0, expBit(8'hA5, i), 4'(i)};
                ntests++;
                if (obs !== exp) begin
                    nfail++;
                    $display("FAIL gap_bit%0d_cyc%0d: got %b expected %b", i, k, obs, exp);
                end
                iEn = (k == 2);
                if (iEn && oLoading) rx = rxShift(rx, oData_out);
                @(negedge iClk);
            end
        end
        iEn = 1'b0;
        exp = {1'b0, 1'b1, 1'b1, 1'b0, 4'd8};
        ntests++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL gap_done: got %b expected %b", obs, exp);
        end
        ntests++;
        if (rx !== 8'hA5) begin
            nfail++;
            $display("FAIL gap_loopback: got %h expected a5", rx);
        end
        @(negedge iClk);
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 4'd8};
        ntests++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL gap_idle: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_restart_ignored();
        iData = 8'hA5; iStart = 1'b1; iEn = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = {1'b1, 1'b1, 1'b0, expBit(8'hA5, i), 4'(i)};
            ntests++;
            if (obs !== exp) begin
                nfail++;
                $display("FAIL restart_bit%0d: got %b expected %b", i, obs, exp);
            end
            if (i == 3 || i == 4) begin
                iStart = 1'b1; iData = 8'hFF;
            end else begin
                iStart = 1'b0;
            end
            @(negedge iClk);
        end
        exp = {1'b0, 1'b1, 1'b1, 1'b0, 4'd8};
        ntests++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL restart_done: got %b expected %b", obs, exp);
        end
        @(negedge iClk);
    endtask

    task automatic test_reset_mid();
        iData = 8'hA5; iStart = 1'b1; iEn = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        repeat (3) @(negedge iClk);
        exp = {1'b1, 1'b1, 1'b0, expBit(8'hA5, 3), 4'd3};
        ntests++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL rstmid_before: got %b expected %b", obs, exp);
        end
        #1;
        iRst = 1'b0;
        #1;
        exp = 8'h00;
        ntests++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL rstmid_async: got %b expected %b", obs, exp);
        end
        @(negedge iClk);
        iRst = 1'b1;
        iData = 8'h3C; iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = {1'b1, 1'b1, 1'b0, expBit(8'h3C, i), 4'(i)};
            ntests++;
            if (obs !== exp) begin
                nfail++;
                $display("FAIL rstmid_3c_bit%0d: got %b expected %b", i, obs, exp);
            end
            @(negedge iClk);
        end
        exp = {1'b0, 1'b1, 1'b1, 1'b0, 4'd8};
        ntests++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL rstmid_done: got %b expected %b", obs, exp);
        end
        @(negedge iClk);
    endtask

    task automatic test_back_to_back();
        iData = 8'h81; iStart = 1'b1; iEn = 1'b1;
        @(negedge iClk);
        // Edge N has passed; iStart stays high, next word waits on the bus.
        iData = 8'h7E;
        rx = 8'h00;
        for (int i = 0; i < 8; i++) begin
            exp = {1'b1, 1'b1, 1'b0, expBit(8'h81, i), 4'(i)};
            ntests++;
            if (obs !== exp) begin
                nfail++;
                $display("FAIL b2b_w0_bit%0d: got %b expected %b", i, obs, exp);
            end
            rx = rxShift(rx, oData_out);
            @(negedge iClk);
        end
        ntests++;
        if (rx !== 8'h81) begin
            nfail++;
            $display("FAIL b2b_w0_rx: got %h expected 81", rx);
        end
        exp = {1'b0, 1'b1, 1'b1, 1'b0, 4'd8};
        ntests++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL b2b_done: got %b expected %b", obs, exp);
        end
        @(negedge iClk);
        // After N+9: back in IDLE, the held start was ignored in DONE.
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 4'd8};
        ntests++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL b2b_gap_idle: got %b expected %b", obs, exp);
        end
        @(negedge iClk);
        // After N+10: second word accepted.
        iStart = 1'b0;
        rx = 8'h00;
        for (int i = 0; i < 8; i++) begin
            exp = {1'b1, 1'b1, 1'b0, expBit(8'h7E, i), 4'(i)};
            ntests++;
            if (obs !== exp) begin
                nfail++;
                $display("FAIL b2b_w1_bit%0d: got %b expected %b", i, obs, exp);
            end
            rx = rxShift(rx, oData_out);
            @(negedge iClk);
        end
        ntests++;
        if (rx !== 8'h7E) begin
            nfail++;
            $display("FAIL b2b_w1_rx: got %h expected 7e", rx);
        end
        exp = {1'b0, 1'b1, 1'b1, 1'b0, 4'd8};
        ntests++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL b2b_w1_done: got %b expected %b", obs, exp);
        end
        @(negedge iClk);
    endtask

    initial begin
        test_reset();
        test_basic(8'hA5);
        test_basic(8'h01);
        test_en_gaps();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
